// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if
//   Word stream from the register-file dump reader to its consumer
//   (SQED consistency checker / debug dump logic).
//
//   out_valid  word valid (producer)
//   out_ready  consumer accepts the word this cycle
//   out_data   captured RAM word
//   out_addr   RAM address the word came from
//   out_last   final word of the requested range
//
//   master: the dump reader; slave: the consumer.
interface regfile_dump_reader_if #(
    parameter int BRAM_ADDR_WIDTH = 5,
    parameter int BRAM_DATA_WIDTH = 32
);
    logic                       out_valid;
    logic                       out_ready;
    logic [BRAM_DATA_WIDTH-1:0] out_data;
    logic [BRAM_ADDR_WIDTH-1:0] out_addr;
    logic                       out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks an inclusive, wrap-around address range of a register-file RAM
//   through one asynchronous read port and streams every word with its
//   address over a valid/ready stream. A running sum of the accepted words
//   is kept in checksum.
//
//   clk, reset_n  clock (rising edge) and asynchronous active-low reset
//   start         command pulse, honoured only while idle
//   first_addr    first address of the range (sampled on accepted start)
//   last_addr     last address of the range, inclusive
//   abort         cancels a dump in progress (no done pulse)
//   raddr/rdata   RAM read port; rdata is combinational from raddr
//   ob            output word stream (master side)
//   busy          high while a dump is running
//   done          one-cycle pulse after the last word is accepted
//   err           one-cycle pulse when a start names an address >= DATA_DEPTH
//   checksum      sum mod 2^BRAM_DATA_WIDTH of the accepted words
module regfile_dump_reader #(
    parameter int BRAM_ADDR_WIDTH = 5,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int DATA_DEPTH      = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [BRAM_ADDR_WIDTH-1:0] first_addr,
    input  logic [BRAM_ADDR_WIDTH-1:0] last_addr,
    input  logic                       abort,
    output logic [BRAM_ADDR_WIDTH-1:0] raddr,
    input  logic [BRAM_DATA_WIDTH-1:0] rdata,
    regfile_dump_reader_if.master      ob,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [BRAM_DATA_WIDTH-1:0] checksum
);

    localparam int REM_W = $clog2(DATA_DEPTH + 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_IDX = BRAM_ADDR_WIDTH'(DATA_DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widened to 32 bits so the test stays meaningful when the address
    // field exactly covers the depth (the comparison is then always true).
    function automatic logic addr_ok(input logic [BRAM_ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(DATA_DEPTH);
    endfunction

    // Number of words in [f..l], wrapping through DATA_DEPTH-1 to 0.
    function automatic logic [REM_W-1:0] span_words(
        input logic [BRAM_ADDR_WIDTH-1:0] f,
        input logic [BRAM_ADDR_WIDTH-1:0] l
    );
        logic [31:0] fe;
        logic [31:0] le;
        logic [31:0] d;
        fe = 32'(f);
        le = 32'(l);
        d  = (le >= fe) ? (le - fe) : (le + 32'(DATA_DEPTH) - fe);
        return REM_W'(d + 32'd1);
    endfunction

    // Pointer advance with wrap at the configured depth (which need not be
    // a power of two).
    function automatic logic [BRAM_ADDR_WIDTH-1:0] next_ptr(
        input logic [BRAM_ADDR_WIDTH-1:0] p
    );
        return (p == LAST_IDX) ? '0 : p + BRAM_ADDR_WIDTH'(1);
    endfunction

    state_t                     state_q;
    logic [BRAM_ADDR_WIDTH-1:0] ptr_q;
    logic [REM_W-1:0]           rem_q;
    logic                       valid_q;
    logic [BRAM_DATA_WIDTH-1:0] data_q;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q;
    logic                       last_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;
    logic [BRAM_DATA_WIDTH-1:0] sum_q;

    logic xfer;
    logic cap;

    // A word leaves on valid&ready; the output register can be refilled in
    // the same cycle, which keeps the stream at one word per clock.
    assign xfer = valid_q & ob.out_ready;
    assign cap  = (rem_q != '0) & (~valid_q | ob.out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            // Accepted words always count, including in an abort cycle.
            if (xfer) begin
                sum_q <= sum_q + data_q;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!addr_ok(first_addr) || !addr_ok(last_addr)) begin
                            err_q <= 1'b1;
                        end else begin
                            ptr_q   <= first_addr;
                            rem_q   <= span_words(first_addr, last_addr);
                            sum_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        rem_q   <= '0;
                    end else if (xfer && last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cap) begin
                        // rdata is sampled at this edge; a same-cycle RAM
                        // write to ptr_q lands afterwards and is not seen.
                        data_q  <= rdata;
                        addr_q  <= ptr_q;
                        last_q  <= (rem_q == REM_W'(1));
                        valid_q <= 1'b1;
                        ptr_q   <= next_ptr(ptr_q);
                        rem_q   <= rem_q - REM_W'(1);
                    end else if (xfer) begin
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign raddr        = ptr_q;
    assign ob.out_valid = valid_q;
    assign ob.out_data  = data_q;
    assign ob.out_addr  = addr_q;
    assign ob.out_last  = last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign checksum     = sum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//   Directed bench for regfile_dump_reader. A 32-entry RAM holding
//   mem[i] = i+1 feeds the main instance; a second instance with a 6-bit
//   address field exercises the out-of-range start rejection.
module tb_regfile_dump_reader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        abort;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    logic [31:0] mem [32];

    logic        start2;
    logic [5:0]  first2;
    logic [5:0]  last2;
    logic        abort2;
    logic [5:0]  raddr2;
    logic [31:0] rdata2;
    logic        busy2;
    logic        done2;
    logic        err2;
    logic [31:0] checksum2;

    int checks;
    int errors;

    regfile_dump_reader_if #(.BRAM_ADDR_WIDTH(5), .BRAM_DATA_WIDTH(32)) sif ();
    regfile_dump_reader_if #(.BRAM_ADDR_WIDTH(6), .BRAM_DATA_WIDTH(32)) sif2 ();

    regfile_dump_reader #(
        .BRAM_ADDR_WIDTH(5),
        .BRAM_DATA_WIDTH(32),
        .DATA_DEPTH(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .first_addr(first_addr),
        .last_addr(last_addr),
        .abort(abort),
        .raddr(raddr),
        .rdata(rdata),
        .ob(sif),
        .busy(busy),
        .done(done),
        .err(err),
        .checksum(checksum)
    );

    regfile_dump_reader #(
        .BRAM_ADDR_WIDTH(6),
        .BRAM_DATA_WIDTH(32),
        .DATA_DEPTH(32)
    ) dut2 (
        .clk(clk),
        .reset_n(reset_n),
        .start(start2),
        .first_addr(first2),
        .last_addr(last2),
        .abort(abort2),
        .raddr(raddr2),
        .rdata(rdata2),
        .ob(sif2),
        .busy(busy2),
        .done(done2),
        .err(err2),
        .checksum(checksum2)
    );

    assign rdata = mem[raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump and checks every visible word against mem[i] = i+1.
    // With stall set, out_ready follows 1,0,0,1,... per cycle.
    task automatic dump(input logic [4:0] f, input logic [4:0] l, input int k,
                        input logic [31:0] exp_sum, input bit stall);
        int          c;
        int          got;
        int          first_vld;
        bit          seen_done;
        bit          prev_stall;
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;
        logic [4:0]  ea;
        logic [3:0]  pat;
        pat        = 4'b1001;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_raddr", raddr, f);
        check("start_novalid", sif.out_valid, 0);
        c = 0; got = 0; first_vld = -1; seen_done = 0; prev_stall = 0;
        prev_addr = '0; prev_data = '0;
        while (!seen_done && c < 200) begin
            tick();
            c++;
            if (done) begin
                seen_done = 1;
            end else if (sif.out_valid) begin
                if (first_vld < 0) first_vld = c;
                if (prev_stall) begin
                    check("stall_addr_stable", sif.out_addr, prev_addr);
                    check("stall_data_stable", sif.out_data, prev_data);
                end
                ea = f + 5'(got);
                check("word_addr", sif.out_addr, ea);
                check("word_data", sif.out_data, 32'(ea) + 32'd1);
                check("word_last", sif.out_last, (got == k - 1));
                prev_addr = sif.out_addr;
                prev_data = sif.out_data;
                sif.out_ready = stall ? pat[c % 4] : 1'b1;
                if (sif.out_ready) got++;
                prev_stall = !sif.out_ready;
            end
        end
        check("done_seen", seen_done, 1);
        check("word_count", got, k);
        check("first_valid_latency", first_vld, 1);
        if (!stall) check("done_cycle", c, k + 1);
        check("checksum", checksum, exp_sum);
        check("done_novalid", sif.out_valid, 0);
        check("done_notbusy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
        reset_n = 1'b0;
        start = 1'b0; first_addr = '0; last_addr = '0; abort = 1'b0;
        sif.out_ready = 1'b1;
        start2 = 1'b0; first2 = '0; last2 = '0; abort2 = 1'b0; rdata2 = '0;
        sif2.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_raddr", raddr, 0);
        check("rst_stream", {sif.out_valid, sif.out_last, sif.out_addr, sif.out_data}, 0);
        check("rst_ctrl", {busy, done, err}, 0);
        check("rst_checksum", checksum, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Full range, no back-pressure: 1+2+...+32 = 528
        dump(5'd0, 5'd31, 32, 32'd528, 1'b0);
        tick();
        check("done_one_cycle", done, 0);

        // Wrap range 30,31,0,1: 31+32+1+2 = 66
        dump(5'd30, 5'd1, 4, 32'd66, 1'b0);

        // Same range with stalls: same words and sum
        dump(5'd30, 5'd1, 4, 32'd66, 1'b1);
        sif.out_ready = 1'b1;

        // Single word at 5, a start during RUN is ignored
        first_addr = 5'd5; last_addr = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("single_busy", busy, 1);
        tick();
        check("single_valid", sif.out_valid, 1);
        check("single_addr", sif.out_addr, 5);
        check("single_data", sif.out_data, 6);
        check("single_last", sif.out_last, 1);
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
        tick();
        check("single_done", done, 1);
        check("single_novalid", sif.out_valid, 0);
        check("single_sum", checksum, 6);
        // New start in the done cycle: range 2..3 -> words 3,4
        first_addr = 5'd2; last_addr = 5'd3;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_raddr", raddr, 2);
        check("restart_nodone", done, 0);
        tick();
        check("restart_w0", {sif.out_valid, sif.out_last, sif.out_addr, sif.out_data}, {1'b1, 1'b0, 5'd2, 32'd3});
        tick();
        check("restart_w1", {sif.out_valid, sif.out_last, sif.out_addr, sif.out_data}, {1'b1, 1'b1, 5'd3, 32'd4});
        tick();
        check("restart_done", done, 1);
        check("restart_sum", checksum, 7);

        // Abort after 3 accepted words: 1+2+3 = 6
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_abort_addr", sif.out_addr, 2);
        abort = 1'b1;
        tick();
        check("abort_novalid", sif.out_valid, 0);
        check("abort_nolast", sif.out_last, 0);
        check("abort_nodone", done, 0);
        check("abort_notbusy", busy, 0);
        check("abort_sum", checksum, 6);
        abort = 1'b0;
        tick();
        check("abort_nodone_later", done, 0);
        check("abort_idle_valid", sif.out_valid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_noeffect", {busy, done, sif.out_valid}, 0);
        check("idle_abort_sum", checksum, 6);

        // Out-of-range start on the 6-bit build
        first2 = 6'd32; last2 = 6'd0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("err_first_pulse", err2, 1);
        check("err_first_idle", busy2, 0);
        tick();
        check("err_one_cycle", err2, 0);
        first2 = 6'd0; last2 = 6'd40; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("err_last_pulse", err2, 1);
        check("err_last_idle", busy2, 0);
        check("err_no_side_effect", {raddr2, checksum2, done2, sif2.out_valid, sif2.out_last, sif2.out_addr, sif2.out_data}, 0);
        check("main_no_err", err, 0);

        // Reset while stalled mid-dump
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; sif.out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sif.out_ready = 1'b0;
        tick();
        check("pre_reset_addr", sif.out_addr, 1);
        check("pre_reset_sum", checksum, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_stream", {sif.out_valid, sif.out_last, sif.out_addr, sif.out_data}, 0);
        check("async_rst_ctrl", {busy, done, err}, 0);
        check("async_rst_raddr", raddr, 0);
        check("async_rst_sum", checksum, 0);
        #1;
        reset_n = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        check("post_rst_idle", {busy, done, sif.out_valid}, 0);
        dump(5'd30, 5'd1, 4, 32'd66, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the multi-port synchronous-write / asynchronous-read register-file RAMs. On a start command it walks an inclusive, wrap-around address range through one RAM read port and streams each word, with its address, over a valid/ready interface. It also keeps a running sum of the accepted words. It sits beside the architectural register file and feeds the SQED consistency checker and debug dump logic without stalling the core's write ports.

## Interface
- BRAM_ADDR_WIDTH, default 5: RAM address width.
- BRAM_DATA_WIDTH, default 32: RAM data width.
- DATA_DEPTH, default 32: number of RAM entries; valid addresses are 0..DATA_DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; accepted only in IDLE.
- first_addr  in  BRAM_ADDR_WIDTH  first address of the range; sampled on accepted start.
- last_addr  in  BRAM_ADDR_WIDTH  last address of the range (inclusive); sampled on accepted start.
- abort  in  1  cancels a dump in progress.
- raddr  out  BRAM_ADDR_WIDTH  RAM read address (registered pointer).
- rdata  in  BRAM_DATA_WIDTH  RAM read data, combinational from raddr.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  BRAM_DATA_WIDTH  captured word.
- out_addr  out  BRAM_ADDR_WIDTH  address of out_data.
- out_last  out  1  marks the final word of the range.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse when a start is rejected for an out-of-range address.
- checksum  out  BRAM_DATA_WIDTH  sum mod 2^BRAM_DATA_WIDTH of the accepted words.

## Operation
- States: IDLE and RUN.
- Reset values: all outputs and registers are 0. This covers raddr, out_*, busy, done, err and checksum. remaining is also 0; it is $clog2(DATA_DEPTH+1) bits wide.

IDLE
- start with first_addr or last_addr >= DATA_DEPTH: err pulses, state stays IDLE, checksum is unchanged.
- Otherwise on start:
  - ptr <= first_addr.
  - remaining <= ((last_addr - first_addr) mod DATA_DEPTH) + 1.
  - checksum <= 0.
  - state goes to RUN.
- first_addr == last_addr means exactly 1 word.
- last_addr < first_addr wraps through DATA_DEPTH-1 to 0.

RUN
- Capture condition: remaining != 0 and (!out_valid or out_ready).
- On capture:
  - out_data <= rdata; out_addr <= ptr; out_last <= (remaining == 1); out_valid <= 1.
  - ptr <= (ptr == DATA_DEPTH-1) ? 0 : ptr+1.
  - remaining decrements by 1.
- Handshake:
  - A word transfers when out_valid && out_ready; checksum += out_data on that cycle.
  - While out_valid && !out_ready, out_data, out_addr and out_last hold stable.
  - On a transfer with out_last: out_valid <= 0, done <= 1, state returns to IDLE.
  - If the transfer is not the last word, the next capture happens in the same cycle, so out_valid stays 1.
- start during RUN is ignored.

Abort
- abort in RUN, including a cycle with a pending handshake: state goes to IDLE, out_valid and out_last <= 0, remaining <= 0, and done does not pulse.
- A handshake that occurs in the abort cycle still counts in checksum.
- abort in IDLE has no effect.

Write coherency
- A captured word is the RAM content at the capture edge.
- A RAM write to the same address in that cycle is not reflected in the captured word; it lands after the edge.

## Timing
- Start-to-first-valid latency: start at edge N puts raddr = first_addr after N. The first capture is at edge N+1, so out_valid rises after N+1.
- Throughput is 1 word/cycle with out_ready held high. A range of K words finishes with done high in the cycle after the last transfer: out_valid covers cycles N+1..N+K, and done is high for cycle N+K+1.
- checksum is final in the same cycle done is high and holds until the next accepted start.
- A new start is accepted in the cycle done is high.
- Reset mid-dump: reset_n low clears all state immediately and asynchronously, with no done pulse.

## Test plan
- RAM preloaded with mem[i] = i+1; start with first=0, last=31, out_ready=1 -> 32 consecutive words with out_addr 0..31, out_last only on 31, done one cycle later, checksum = 528.
- Wrap range first=30, last=1 -> out_addr sequence 30, 31, 0, 1 with data 31, 32, 1, 2; checksum = 66.
- Same range with out_ready toggled 1,0,0,1,... -> out_data/out_addr stable while stalled, no word lost or duplicated, checksum unchanged vs. out_ready=1.
- first=last=5, plus start re-pulsed during RUN -> exactly one word (addr 5); the second start is ignored; a start in the done cycle begins a new dump.
- abort after 3 accepted words of 0..31 -> out_valid low next cycle, no done, checksum = 6. Separately, a start with first_addr=32 and DATA_DEPTH=32 (BRAM_ADDR_WIDTH=6 build) -> err pulse, stays IDLE.
- reset_n asserted while stalled mid-dump -> all outputs 0 immediately, busy=0; a subsequent start runs normally.
